// File: rtl/neuron_spike_collector.sv
// Neuron spike-report collector: captures each neuron's sticky report once per
// inference and serialises the reports, tagged with the neuron ID, onto one
// AXI-Stream master. Raises done once every report has been accepted.
module neuron_spike_collector #(
  parameter int unsigned N  = 4,
  parameter int unsigned S  = 8,
  parameter int unsigned TW = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [N-1:0]      s_tvalid,
  input  logic [N*S-1:0]    s_tdata,
  input  logic [N*TW-1:0]   s_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [S-1:0]      m_tdata,
  output logic [IW+TW-1:0]  m_tuser,
  output logic              m_tlast,
  output logic [N-1:0]      captured,
  output logic              done
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {SCAN, SEND, DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [S-1:0]      m_tdata_q, m_tdata_d;
  logic [IW+TW-1:0]  m_tuser_q, m_tuser_d;
  logic              m_tlast_q, m_tlast_d;
  logic [N-1:0]      captured_q, captured_d;
  logic              done_q, done_d;

  logic [N-1:0]      elig;
  logic              grant_vld;
  logic [IW-1:0]     grant_idx;
  logic [S-1:0]      sel_tdata;
  logic [TW-1:0]     sel_tuser;
  logic              free;
  logic              load;
  logic              hs;

  // Round-robin arbiter: first eligible neuron at or after rr_q, wrapping.
  always_comb begin : arb_p
    int unsigned idx;
    elig      = s_tvalid & ~captured_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < int'(N); k++) begin
      idx = (32'(rr_q) + 32'(k)) % N;
      if (!grant_vld && elig[IW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  // Payload mux for the granted neuron.
  always_comb begin
    sel_tdata = '0;
    sel_tuser = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (grant_idx == IW'(j)) begin
        sel_tdata = s_tdata[j*S +: S];
        sel_tuser = s_tuser[j*TW +: TW];
      end
    end
  end

  // Next-state: output register load/drain, beat counting and FSM.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    captured_d = captured_q;

    free = !m_tvalid_q || m_tready;
    hs   = m_tvalid_q && m_tready;
    load = grant_vld && free && (state_q != DONE);

    if (load) begin
      m_tdata_d  = sel_tdata;
      m_tuser_d  = {grant_idx, sel_tuser};
      captured_d = captured_q | (N'(1) << grant_idx);
      m_tvalid_d = 1'b1;
      m_tlast_d  = (cnt_q == CW'(N - 1));
      cnt_d      = (cnt_q == CW'(N)) ? cnt_q : cnt_q + CW'(1);
      rr_d       = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end else if (free) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      SCAN:    if (load) state_d = SEND;
      SEND:    if (hs && m_tlast_q) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = SCAN;
    endcase

    done_d = (state_d == DONE);
  end

  // State registers; clear behaves exactly like reset and wins over a handshake.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= SCAN;
      rr_q       <= '0;
      cnt_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
      captured_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      captured_q <= captured_d;
      done_q     <= done_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tuser  = m_tuser_q;
  assign m_tlast  = m_tlast_q;
  assign captured = captured_q;
  assign done     = done_q;

endmodule

// File: tb/tb_neuron_spike_collector.sv
// Directed bench for neuron_spike_collector (N=4, S=8, TW=4).
module tb_neuron_spike_collector;

  localparam int unsigned N  = 4;
  localparam int unsigned S  = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic [N-1:0]      s_tvalid;
  logic [N*S-1:0]    s_tdata;
  logic [N*TW-1:0]   s_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic [S-1:0]      m_tdata;
  logic [IW+TW-1:0]  m_tuser;
  logic              m_tlast;
  logic [N-1:0]      captured;
  logic              done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] tdat [N] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
  logic [3:0] tus  [N] = '{4'd3, 4'd7, 4'd9, 4'hF};

  neuron_spike_collector #(.N(N), .S(S), .TW(TW)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tuser  (s_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast),
    .captured (captured),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a valid beat from neuron id.
  task automatic expect_beat(input string tag, input int id, input logic last);
    check({tag, ".tvalid"}, 32'(m_tvalid), 32'd1);
    check({tag, ".tdata"},  32'(m_tdata),  32'(tdat[id]));
    check({tag, ".tuser"},  32'(m_tuser),  32'(id * 16) + 32'(tus[id]));
    check({tag, ".tlast"},  32'(m_tlast),  32'(last));
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    s_tvalid = '0;
    m_tready = 1'b1;
    for (int j = 0; j < int'(N); j++) begin
      s_tdata[j*S +: S]   = tdat[j];
      s_tuser[j*TW +: TW] = tus[j];
    end
    tick();
    tick();
    reset = 1'b0;
    check("rst.tvalid",   32'(m_tvalid), 32'd0);
    check("rst.tdata",    32'(m_tdata),  32'd0);
    check("rst.tuser",    32'(m_tuser),  32'd0);
    check("rst.tlast",    32'(m_tlast),  32'd0);
    check("rst.captured", 32'(captured), 32'd0);
    check("rst.done",     32'(done),     32'd0);

    // Single source, then sticky valid must not re-fire.
    s_tvalid = 4'b0001;
    tick();
    expect_beat("t1.beat", 0, 1'b0);
    check("t1.captured", 32'(captured), 32'h1);
    tick();
    check("t1.drain", 32'(m_tvalid), 32'd0);
    check("t1.hold",  32'(m_tdata),  32'hA5);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t1.quiet", 32'(m_tvalid), 32'd0);
    end

    // All simultaneous: IDs 0..3 back to back, tlast on ID3, then done.
    s_tvalid = '0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    check("t2.clr_captured", 32'(captured), 32'd0);
    s_tvalid = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      tick();
      expect_beat("t2.beat", j, 1'(j == 3));
      check("t2.notdone", 32'(done), 32'd0);
    end
    tick();
    check("t2.done",     32'(done),     32'd1);
    check("t2.tvalid",   32'(m_tvalid), 32'd0);
    check("t2.captured", 32'(captured), 32'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t2.idle", 32'(m_tvalid), 32'd0);
      check("t2.held", 32'(done),     32'd1);
    end

    // Reset in DONE: state cleared, sticky inputs re-forwarded from ID0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6.done",     32'(done),     32'd0);
    check("t6.tvalid",   32'(m_tvalid), 32'd0);
    check("t6.captured", 32'(captured), 32'd0);
    tick();
    expect_beat("t6.beat", 0, 1'b0);
    s_tvalid = '0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;

    // Backpressure: first beat held stable, second waits.
    m_tready = 1'b0;
    s_tvalid = 4'b0011;
    tick();
    expect_beat("t3.first", 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_beat("t3.stall", 0, 1'b0);
      check("t3.captured", 32'(captured), 32'h1);
    end
    m_tready = 1'b1;
    tick();
    expect_beat("t3.second", 1, 1'b0);
    check("t3.captured2", 32'(captured), 32'h3);
    tick();
    check("t3.drain", 32'(m_tvalid), 32'd0);
    s_tvalid = '0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;

    // Round robin: ID2 first, then 0 and 3 together -> ID3 before ID0.
    s_tvalid = 4'b0100;
    tick();
    expect_beat("t4.id2", 2, 1'b0);
    s_tvalid = 4'b1101;
    tick();
    expect_beat("t4.id3", 3, 1'b0);
    tick();
    expect_beat("t4.id0", 0, 1'b0);

    // Clear during a handshake: beat abandoned, re-forward from ID0.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5.tvalid",   32'(m_tvalid), 32'd0);
    check("t5.captured", 32'(captured), 32'd0);
    check("t5.done",     32'(done),     32'd0);
    tick();
    expect_beat("t5.id0", 0, 1'b0);
    tick();
    expect_beat("t5.id2", 2, 1'b0);
    tick();
    expect_beat("t5.id3", 3, 1'b0);
    s_tvalid = 4'b1111;
    tick();
    expect_beat("t5.id1", 1, 1'b1);
    tick();
    check("t5.done_end", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
